nibble_serial_adder_ctrl: RTL and testbench



---
 rtl/nibble_serial_adder_ctrl_pkg.sv | 15 +
 rtl/nibble_serial_adder_ctrl_if.sv | 31 +++
 rtl/nibble_serial_adder_ctrl_adder4.sv | 23 ++
 rtl/nibble_serial_adder_ctrl.sv | 119 +++++++++++
 tb/tb_nibble_serial_adder_ctrl.sv | 168 ++++++++++++++++
 5 files changed

// File: rtl/nibble_serial_adder_ctrl_pkg.sv
// rtl/nibble_serial_adder_ctrl_pkg.sv - shared types and constants for the nibble-serial adder
package nibble_serial_adder_ctrl_pkg;

  // Width of the shared arithmetic slice and log2 of it (used to form bit offsets)
  localparam int NIBBLE_W    = 4;
  localparam int NIBBLE_LOG2 = 2;

  // Controller states: wait for start, walk the nibbles, pulse done
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/nibble_serial_adder_ctrl_if.sv
// rtl/nibble_serial_adder_ctrl_if.sv - request/result bundle between a requester and the adder
interface nibble_serial_adder_ctrl_if #(
  parameter int NIBBLES = 4
);
  import nibble_serial_adder_ctrl_pkg::*;

  localparam int W = NIBBLE_W * NIBBLES;

  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         c_out;
  logic         ovf;

  // Requester side: issues operations and reads back the result
  modport master (
    output start, sub, a, b,
    input  busy, done, result, c_out, ovf
  );

  // Adder side: accepts operations and reports the result
  modport slave (
    input  start, sub, a, b,
    output busy, done, result, c_out, ovf
  );

endinterface

// File: rtl/nibble_serial_adder_ctrl_adder4.sv
// rtl/nibble_serial_adder_ctrl_adder4.sv - 4-bit ripple slice exposing sum and signed overflow only
module adder4 (
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       c_in,
  output logic [3:0] s,
  output logic       v
);

  logic [4:0] c;

  assign c[0] = c_in;

  // Classic full-adder ripple chain
  for (genvar i = 0; i < 4; i++) begin : g_bit
    assign s[i]   = x[i] ^ y[i] ^ c[i];
    assign c[i+1] = (x[i] & y[i]) | ((x[i] ^ y[i]) & c[i]);
  end

  // Overflow: carry into the top bit disagrees with carry out of it
  assign v = c[4] ^ c[3];

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// rtl/nibble_serial_adder_ctrl.sv - sequences one 4-bit slice over a wide add/subtract, LS nibble first
module nibble_serial_adder_ctrl
  import nibble_serial_adder_ctrl_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  nibble_serial_adder_ctrl_if.slave   bus
);

  localparam int W     = NIBBLE_W * NIBBLES;
  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  state_e           state_q,  state_d;
  logic [IDX_W-1:0] idx_q,    idx_d;
  logic             carry_q,  carry_d;
  logic [W-1:0]     op_a_q,   op_a_d;
  logic [W-1:0]     op_b_q,   op_b_d;
  logic [W-1:0]     result_q, result_d;
  logic             c_out_q,  c_out_d;
  logic             ovf_q,    ovf_d;

  logic [IDX_W+NIBBLE_LOG2-1:0] bit_ofs;
  logic [NIBBLE_W-1:0]          slice_x;
  logic [NIBBLE_W-1:0]          slice_y;
  logic [NIBBLE_W-1:0]          slice_s;
  logic                         slice_v;
  logic                         c3;
  logic                         carry_next;

  // Bit offset of the current nibble (idx * 4)
  assign bit_ofs = {idx_q, {NIBBLE_LOG2{1'b0}}};
  assign slice_x = op_a_q[bit_ofs +: NIBBLE_W];
  assign slice_y = op_b_q[bit_ofs +: NIBBLE_W];

  adder4 u_slice (
    .x    (slice_x),
    .y    (slice_y),
    .c_in (carry_q),
    .s    (slice_s),
    .v    (slice_v)
  );

  // The slice hides its carry-out; rebuild it from the carry into bit 3
  assign c3         = slice_s[3] ^ slice_x[3] ^ slice_y[3];
  assign carry_next = (slice_x[3] & slice_y[3]) | ((slice_x[3] ^ slice_y[3]) & c3);

  // Next-state and datapath updates; subtract is a + ~b + 1
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    carry_d  = carry_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    result_d = result_q;
    c_out_d  = c_out_q;
    ovf_d    = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          op_a_d  = bus.a;
          op_b_d  = bus.sub ? ~bus.b : bus.b;
          carry_d = bus.sub;
          idx_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        result_d[bit_ofs +: NIBBLE_W] = slice_s;
        carry_d = carry_next;
        if (idx_q == LAST_IDX) begin
          c_out_d = carry_next;
          ovf_d   = slice_v;
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      op_a_q   <= '0;
      op_b_q   <= '0;
      result_q <= '0;
      c_out_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      carry_q  <= carry_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      result_q <= result_d;
      c_out_q  <= c_out_d;
      ovf_q    <= ovf_d;
    end
  end

  assign bus.busy   = (state_q != ST_IDLE);
  assign bus.done   = (state_q == ST_DONE);
  assign bus.result = result_q;
  assign bus.c_out  = c_out_q;
  assign bus.ovf    = ovf_q;

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// tb/tb_nibble_serial_adder_ctrl.sv - directed table-driven bench for the nibble-serial adder
module tb_nibble_serial_adder_ctrl;

  localparam int NIBBLES = 4;

  typedef struct {
    logic        sub;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    logic        c;
    logic        v;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  vec_t vecs[8];

  nibble_serial_adder_ctrl_if #(.NIBBLES(NIBBLES)) bus_if ();

  nibble_serial_adder_ctrl #(.NIBBLES(NIBBLES)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // One operation: start at a negedge, watch every cycle until done, then check hold behaviour
  task automatic do_op(input logic s, input logic [15:0] x, input logic [15:0] y,
                       input logic [15:0] er, input logic ec, input logic ev,
                       input bit scramble, input int inject_cyc, input bit inject_done);
    int cyc;
    bit seen;
    @(negedge clk);
    bus_if.start = 1'b1;
    bus_if.sub   = s;
    bus_if.a     = x;
    bus_if.b     = y;
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
      bus_if.start = 1'b0;
      if (scramble) begin
        bus_if.a   = 16'($urandom);
        bus_if.b   = 16'($urandom);
        bus_if.sub = 1'($urandom);
      end
      if (cyc == inject_cyc) begin
        bus_if.start = 1'b1;
        bus_if.a     = ~x;
        bus_if.b     = 16'h0F0F;
        bus_if.sub   = ~s;
      end
      check("busy_high", 32'(bus_if.busy), 32'd1);
      if (bus_if.done) begin
        seen = 1'b1;
        if (inject_done) begin
          bus_if.start = 1'b1;
          bus_if.a     = 16'hAAAA;
          bus_if.b     = 16'h5555;
          bus_if.sub   = 1'b0;
        end
      end
    end
    check("done_latency", 32'(seen ? cyc : 99), 32'(NIBBLES + 1));
    check("result", 32'(bus_if.result), 32'(er));
    check("c_out", 32'(bus_if.c_out), 32'(ec));
    check("ovf", 32'(bus_if.ovf), 32'(ev));
    @(posedge clk);
    #1;
    bus_if.start = 1'b0;
    check("done_pulse", 32'(bus_if.done), 32'd0);
    check("busy_low_after", 32'(bus_if.busy), 32'd0);
    @(posedge clk);
    #1;
    check("idle_stays", 32'(bus_if.busy), 32'd0);
    check("result_held", 32'(bus_if.result), 32'(er));
    check("c_out_held", 32'(bus_if.c_out), 32'(ec));
  endtask

  initial begin
    bit seen_done;

    vecs[0] = '{1'b0, 16'h1234, 16'h4321, 16'h5555, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1};
    vecs[3] = '{1'b1, 16'h0005, 16'h0007, 16'hFFFE, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1};
    vecs[5] = '{1'b0, 16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b1};
    vecs[6] = '{1'b1, 16'h1234, 16'h1234, 16'h0000, 1'b1, 1'b0};
    vecs[7] = '{1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0};

    bus_if.start = 1'b0;
    bus_if.sub   = 1'b0;
    bus_if.a     = 16'h0;
    bus_if.b     = 16'h0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(bus_if.busy), 32'd0);
    check("rst_done", 32'(bus_if.done), 32'd0);
    check("rst_result", 32'(bus_if.result), 32'd0);
    check("rst_c_out", 32'(bus_if.c_out), 32'd0);
    check("rst_ovf", 32'(bus_if.ovf), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table of plain operations
    for (int i = 0; i < 8; i++) begin
      do_op(vecs[i].sub, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].c, vecs[i].v, 1'b0, 0, 1'b0);
    end

    // start during RUN and during DONE must be ignored
    do_op(1'b0, 16'h1234, 16'h4321, 16'h5555, 1'b0, 1'b0, 1'b0, 2, 1'b1);

    // Inputs scrambled every cycle after acceptance; latched copies govern the result
    do_op(1'b1, 16'h9ABC, 16'h1357, 16'h8765, 1'b1, 1'b0, 1'b1, 0, 1'b0);

    // Asynchronous reset part-way through RUN (nibble index 2)
    @(negedge clk);
    bus_if.start = 1'b1;
    bus_if.sub   = 1'b0;
    bus_if.a     = 16'h1234;
    bus_if.b     = 16'h4321;
    repeat (3) begin
      @(posedge clk);
      #1;
      bus_if.start = 1'b0;
    end
    check("abort_busy_before", 32'(bus_if.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(bus_if.busy), 32'd0);
    check("abort_done", 32'(bus_if.done), 32'd0);
    check("abort_result", 32'(bus_if.result), 32'd0);
    check("abort_c_out", 32'(bus_if.c_out), 32'd0);
    check("abort_ovf", 32'(bus_if.ovf), 32'd0);
    seen_done = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (bus_if.done) seen_done = 1'b1;
    end
    check("abort_no_done", 32'(seen_done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    do_op(1'b0, 16'h0F0F, 16'h0101, 16'h1010, 1'b0, 1'b0, 1'b0, 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
